// File: rtl/rv32i_types_pkg.sv
// rv32i_types: shared RV32I decode types.
//   instr_fmt_t : instruction format classification (ILL marks an illegal lane)
//   decoded_t   : one fully decoded lane (pc, raw fields, immediate, format, illegal)
//   opcode and legal-funct3 constants, plus the immediate builder used by the lanes.
package rv32i_types;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } instr_fmt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    instr_fmt_t  fmt;
    logic        illegal;
  } decoded_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Legal funct3 sets as bitmasks indexed by funct3.
  localparam logic [7:0] LOAD_F3_LEGAL   = 8'b0011_0111; // lb lh lw lbu lhu
  localparam logic [7:0] STORE_F3_LEGAL  = 8'b0000_0111; // sb sh sw
  localparam logic [7:0] BRANCH_F3_LEGAL = 8'b1111_0011; // beq bne blt bge bltu bgeu
  localparam logic [2:0] JALR_F3         = 3'b000;
  localparam logic [6:0] F7_BASE         = 7'b0000000;
  localparam logic [6:0] F7_ALT          = 7'b0100000;

  function automatic logic [31:0] build_imm(input logic [31:0] ins, input instr_fmt_t f);
    logic [31:0] imm;
    case (f)
      FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm = {ins[31:12], 12'b0};
      FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv32i_decode_pipe_lane.sv
// rv32i_lane_decode: purely combinational single-lane RV32I decoder.
//   instr_i : 32-bit instruction word
//   pc_i    : PC of this lane
//   dec_o   : decoded lane (raw fields, immediate, format, illegal flag)
module rv32i_lane_decode
  import rv32i_types::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output decoded_t    dec_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  instr_fmt_t fmt;
  logic       legal;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  always_comb begin
    fmt   = FMT_ILL;
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin fmt = FMT_U; legal = 1'b1; end
      OP_JAL:           begin fmt = FMT_J; legal = 1'b1; end
      OP_JALR:          begin fmt = FMT_I; legal = (f3 == JALR_F3); end
      OP_LOAD:          begin fmt = FMT_I; legal = LOAD_F3_LEGAL[f3]; end
      OP_STORE:         begin fmt = FMT_S; legal = STORE_F3_LEGAL[f3]; end
      OP_BRANCH:        begin fmt = FMT_B; legal = BRANCH_F3_LEGAL[f3]; end
      OP_IMM: begin
        fmt = FMT_I;
        // slli needs funct7 zero; srli/srai use funct7 as the shift-type selector.
        legal = !((f3 == 3'b001) && (f7 != F7_BASE)) &&
                !((f3 == 3'b101) && (f7 != F7_BASE) && (f7 != F7_ALT));
      end
      OP_REG: begin
        fmt   = FMT_R;
        legal = (f7 == F7_BASE) ||
                ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      default: begin fmt = FMT_ILL; legal = 1'b0; end
    endcase
  end

  always_comb begin
    dec_o.pc      = pc_i;
    dec_o.opcode  = opcode;
    dec_o.funct3  = f3;
    dec_o.funct7  = f7;
    dec_o.rd      = instr_i[11:7];
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = instr_i[24:20];
    dec_o.illegal = !legal;
    dec_o.fmt     = legal ? fmt : FMT_ILL;
    dec_o.imm     = legal ? build_imm(instr_i, fmt) : 32'd0;
  end

endmodule

// File: rtl/rv32i_decode_pipe.sv
// rv32i_decode_pipe: LANES-wide RV32I decode stage behind a 2-entry skid buffer.
//   clk, rst (sync active-high), flush (drops buffered bundles)
//   in_valid/in_ready/in_instr/in_pc       : fetch-side bundle handshake
//   out_valid/out_ready/out_*              : decoded bundle, per-lane fields packed by lane
//   illegal_count                          : saturating count of delivered illegal lanes
// The buffer is a head register (drives the outputs) plus one skid entry; occupancy is
// head_vld_q + skid_vld_q, and the head payload holds its value when it empties.
module rv32i_decode_pipe
  import rv32i_types::*;
#(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_instr,
  input  logic [31:0]           in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_pc,
  output logic [7*LANES-1:0]    out_opcode,
  output logic [3*LANES-1:0]    out_funct3,
  output logic [7*LANES-1:0]    out_funct7,
  output logic [5*LANES-1:0]    out_rd,
  output logic [5*LANES-1:0]    out_rs1,
  output logic [5*LANES-1:0]    out_rs2,
  output logic [32*LANES-1:0]   out_imm,
  output logic [3*LANES-1:0]    out_fmt,
  output logic [LANES-1:0]      out_illegal,
  output logic [CNT_W-1:0]      illegal_count
);

  decoded_t [LANES-1:0] in_dec;
  decoded_t [LANES-1:0] head_q, head_d, skid_q, skid_d;
  logic                 head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           ill_pop;
  logic                 push, pop;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W+2:0] s;
    s = {3'b000, a} + {{CNT_W{1'b0}}, b};
    return (|s[CNT_W+2:CNT_W]) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rv32i_lane_decode u_dec (
      .instr_i (in_instr[32*i +: 32]),
      .pc_i    (in_pc + (32'(i) << 2)),
      .dec_o   (in_dec[i])
    );
    assign out_pc[32*i +: 32]    = head_q[i].pc;
    assign out_opcode[7*i +: 7]  = head_q[i].opcode;
    assign out_funct3[3*i +: 3]  = head_q[i].funct3;
    assign out_funct7[7*i +: 7]  = head_q[i].funct7;
    assign out_rd[5*i +: 5]      = head_q[i].rd;
    assign out_rs1[5*i +: 5]     = head_q[i].rs1;
    assign out_rs2[5*i +: 5]     = head_q[i].rs2;
    assign out_imm[32*i +: 32]   = head_q[i].imm;
    assign out_fmt[3*i +: 3]     = head_q[i].fmt;
    assign out_illegal[i]        = head_q[i].illegal;
  end

  assign in_ready      = !(head_vld_q && skid_vld_q) && !rst;
  assign out_valid     = head_vld_q;
  assign illegal_count = cnt_q;
  assign push          = in_valid && in_ready;
  assign pop           = head_vld_q && out_ready;

  always_comb begin
    ill_pop = 3'd0;
    for (int i = 0; i < LANES; i++) ill_pop = ill_pop + {2'b00, head_q[i].illegal};
  end

  always_comb begin
    head_d     = head_q;
    skid_d     = skid_q;
    head_vld_d = head_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = pop ? sat_add(cnt_q, ill_pop) : cnt_q;
    if (flush) begin
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!head_vld_q || pop) begin
      // Head slot frees up: refill from the skid entry first to keep FIFO order.
      if (skid_vld_q) begin
        head_d     = skid_q;
        head_vld_d = 1'b1;
        skid_vld_d = push;
        if (push) skid_d = in_dec;
      end else begin
        head_vld_d = push;
        if (push) head_d = in_dec;
      end
    end else if (push) begin
      skid_d     = in_dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
      head_q     <= '0;
    end else begin
      head_vld_q <= head_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: doc/rv32i_decode_pipe.md
# rv32i_decode_pipe

Parametrised, multi-lane RV32I decode stage with a valid/ready skid buffer. It sits between instruction fetch and the register-read stage of the `mp_verif` core and accepts a bundle of `LANES` consecutive instruction words per handshake. Each word is split into fields, its sign-extended immediate is built, and it is classified as R/I/S/B/U/J or illegal. A saturating illegal-instruction counter is kept for the random-instruction bench.

## Interface
Parameters:
- `LANES`, 1, instructions per bundle (legal 1..4)
- `CNT_W`, 16, width of the illegal-instruction counter

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: synchronous; discards all buffered bundles
- `in_valid` in 1: bundle offered
- `in_ready` out 1: stage can accept
- `in_instr` in 32*LANES: lane i at bits [32i+31:32i]
- `in_pc` in 32: PC of lane 0; lane i PC = `in_pc` + 4i (mod 2^32)
- `out_valid` out 1: decoded bundle available
- `out_ready` in 1: consumer accepts
- `out_pc` out 32*LANES: per-lane PC
- `out_opcode` out 7*LANES; `out_funct3` out 3*LANES; `out_funct7` out 7*LANES
- `out_rd`, `out_rs1`, `out_rs2` out 5*LANES each
- `out_imm` out 32*LANES: per-lane immediate
- `out_fmt` out 3*LANES: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7
- `out_illegal` out LANES: per-lane illegal flag
- `illegal_count` out CNT_W: saturating count of illegal lanes delivered

## Operation
- Each lane decodes combinationally on the input side. The decoded bundle is written into a 2-entry skid buffer. Entries leave in FIFO order.
- Field extraction is raw for all lanes: rd=[11:7], rs1=[19:15], rs2=[24:20], funct3=[14:12], funct7=[31:25].
- Immediates:
  - I: sext([31:20])
  - S: sext({[31:25],[11:7]})
  - B: sext({[31],[7],[30:25],[11:8],0})
  - U: {[31:12],12'b0}
  - J: sext({[31],[19:12],[20],[30:21],0})
  - R or illegal: 0
- Format by opcode:
  - lui/auipc → U; jal → J; jalr, load, imm → I; store → S; branch → B; reg → R.
- Legality. A lane is illegal (`out_illegal` = 1, `out_fmt` = ILL, `out_imm` = 0) when any of the following holds:
  - the opcode is not one of the nine RV32I base opcodes
  - load with funct3 ∉ {000,001,010,100,101}
  - store with funct3 > 010
  - branch with funct3 ∈ {010,011}
  - jalr with funct3 ≠ 000
  - reg with funct7 ∉ {0000000, 0100000}, or funct7 = 0100000 with funct3 ∉ {000,101}
  - imm with funct3 = 001 and funct7 ≠ 0000000
  - imm with funct3 = 101 and funct7 ∉ {0000000, 0100000}
- Illegal counter: on each output handshake, `illegal_count` += popcount(`out_illegal`), saturating at 2^CNT_W−1. Cleared only by `rst`, never by `flush`.

## Timing
- Latency: a bundle accepted at edge N has `out_valid` = 1 after edge N. Throughput is 1 bundle/cycle when `out_ready` = 1.
- Handshakes:
  - Input accept = `in_valid` & `in_ready`.
  - Output transfer = `out_valid` & `out_ready`.
  - `in_ready` = (occupancy < 2) & !`rst`. It depends only on registered state, never on `in_valid` or `out_ready`.
- Full case: occupancy 2 gives `in_ready` = 0. If a push and a pop happen in the same cycle, occupancy is unchanged.
- Output hold: outputs are stable while `out_valid` & !`out_ready`. When `out_valid` = 0, the payload holds its last value.
- Reset:
  - `out_valid` = 0, occupancy 0, `illegal_count` = 0, all payload outputs 0.
  - `in_ready` = 0 while `rst` is high and 1 on the first cycle after it deasserts.
  - Reset mid-transfer drops all bundles.
- Flush:
  - Occupancy becomes 0 at the next edge, so `out_valid` = 0 the next cycle.
  - Any input accept in the flush cycle is discarded.
  - A simultaneous output handshake still counts illegals.
  - `rst` overrides `flush`.
- PC wrap: 0xFFFFFFFC + 4 = 0x00000000.

## Structure
- Extend the `rv32i_types` package with:
  - `instr_fmt_t` enum (encodings above)
  - `decoded_t` packed struct (pc, opcode, funct3, funct7, rd, rs1, rs2, imm, fmt, illegal)
  - legal funct3 constants
- Sub-module `rv32i_lane_decode` is purely combinational, maps (instr, pc) to `decoded_t`, and is instantiated LANES times.
- The top level holds the 2-entry skid buffer, occupancy/pointer state, and the counter.

## Test plan
- LANES=1, addi x1,x2,-1 (0xFFF10093) → one cycle later: rd=1, rs1=2, imm=0xFFFFFFFF, fmt=I, illegal=0.
- beq x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, fmt=B. sw x2,8(x1) (0x0020A423) → imm=0x00000008, fmt=S.
- Illegal cases, each giving fmt=ILL, imm=0 and `illegal_count` +1 per delivered lane:
  - jalr with funct3=001 (0x000090E7)
  - xor with funct7=0100000 (0x4020C0B3)
  - opcode 0x7F
- Back-pressure: `in_valid` held high with 5 distinct bundles, `out_ready` low for 3 cycles → exactly 2 accepted, `in_ready` = 0. After release, all 5 emerge in order with none lost or duplicated.
- LANES=2, `in_pc` = 0x100, lanes lui x5,0x12345 (0x123452B7) and jal x1,+8 (0x008000EF) → `out_pc` 0x100/0x104, imm 0x12345000/0x00000008, fmt U/J.
- Flush and saturation:
  - Occupancy 2 with flush and `in_valid` high → `out_valid` = 0 next cycle, nothing accepted.
  - CNT_W=4, 20 illegal lanes delivered → `illegal_count` = 15.
  - Counter unchanged by flush and zeroed by `rst`.
